// File: rtl/cla5_arbiter.sv
// ---------------------------------------------------------------------------
// cla5_arbiter
//
// Round-robin arbiter sharing one external, purely combinational 5-bit
// carry-look-ahead adder (cla_5) between two requesters.  Each requester
// offers an operand pair over a valid/ready handshake.  The granted pair is
// steered onto the adder.  The 6-bit result is captured into that
// requester's one-entry response slot.  The requester drains the slot over
// its own valid/ready handshake.
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   req_valid0/1             requester has an operand pair
//   req_ready0/1             grant: pair accepted this cycle (combinational)
//   req_a0/b0, req_a1/b1     5-bit operands
//   rsp_valid0/1             response slot holds a sum
//   rsp_ready0/1             requester takes the sum
//   rsp_sum0/1               registered 6-bit sum (bit 5 = carry-out)
//   add_a, add_b             operands driven to the shared cla_5
//   add_sum                  combinational sum returned by cla_5
//   gnt_cnt0/1               wrapping grant counters, CNT_W bits each
// ---------------------------------------------------------------------------
module cla5_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [4:0]       req_a0,
    input  logic [4:0]       req_b0,

    input  logic             req_valid1,
    output logic             req_ready1,
    input  logic [4:0]       req_a1,
    input  logic [4:0]       req_b1,

    output logic             rsp_valid0,
    input  logic             rsp_ready0,
    output logic [5:0]       rsp_sum0,

    output logic             rsp_valid1,
    input  logic             rsp_ready1,
    output logic [5:0]       rsp_sum1,

    output logic [4:0]       add_a,
    output logic [4:0]       add_b,
    input  logic [5:0]       add_sum,

    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    // last = index of the requester granted most recently.  The reset value
    // of 1 lets requester 0 win the first contested cycle.
    logic last;

    logic elig0, elig1;
    logic gnt0, gnt1;

    // A requester may be granted only if its slot is empty or is being
    // drained this same cycle.  Draining and refilling in one cycle is what
    // sustains one add per cycle for a single requester.
    assign elig0 = req_valid0 & (~rsp_valid0 | rsp_ready0);
    assign elig1 = req_valid1 & (~rsp_valid1 | rsp_ready1);

    // On contention, the requester that was not served last wins.  Grants are
    // masked during reset, so nothing is accepted while rst is high.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                gnt0 = last;
                gnt1 = ~last;
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    assign req_ready0 = gnt0;
    assign req_ready1 = gnt1;

    // Drive the adder inputs to zero when there is no grant.  Idle cycles
    // then leave the adder inputs quiet.
    always_comb begin
        add_a = 5'd0;
        add_b = 5'd0;
        if (gnt0) begin
            add_a = req_a0;
            add_b = req_b0;
        end else if (gnt1) begin
            add_a = req_a1;
            add_b = req_b1;
        end
    end

    // Arbitration history
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (gnt0) begin
            last <= 1'b0;
        end else if (gnt1) begin
            last <= 1'b1;
        end
    end

    // Requester 0 response slot and counter.
    // A new grant takes priority over a drain, so a slot that is drained and
    // refilled in the same cycle stays valid with the fresh sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid0 <= 1'b0;
            rsp_sum0   <= 6'd0;
            gnt_cnt0   <= '0;
        end else if (gnt0) begin
            rsp_valid0 <= 1'b1;
            rsp_sum0   <= add_sum;
            gnt_cnt0   <= gnt_cnt0 + CNT_W'(1);
        end else if (rsp_ready0) begin
            rsp_valid0 <= 1'b0;
        end
    end

    // Requester 1 response slot and counter (same policy as slot 0)
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid1 <= 1'b0;
            rsp_sum1   <= 6'd0;
            gnt_cnt1   <= '0;
        end else if (gnt1) begin
            rsp_valid1 <= 1'b1;
            rsp_sum1   <= add_sum;
            gnt_cnt1   <= gnt_cnt1 + CNT_W'(1);
        end else if (rsp_ready1) begin
            rsp_valid1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla5_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cla5_arbiter
//
// Self-checking bench for cla5_arbiter.  The bench stands in for the shared
// cla_5 with a plain addition.  A transaction-level model tracks each
// requester's slot contents, the grant history and the grant counts.  The
// stimulus combines directed scenarios with a randomized phase.
// ---------------------------------------------------------------------------
module tb_cla5_arbiter;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid0, req_valid1;
    logic             req_ready0, req_ready1;
    logic [4:0]       req_a0, req_b0, req_a1, req_b1;
    logic             rsp_valid0, rsp_valid1;
    logic             rsp_ready0, rsp_ready1;
    logic [5:0]       rsp_sum0, rsp_sum1;
    logic [4:0]       add_a, add_b;
    logic [5:0]       add_sum;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    always #5 clk = ~clk;

    // Stand-in for the shared cla_5
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    cla5_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(req_valid0), .req_ready0(req_ready0),
        .req_a0(req_a0), .req_b0(req_b0),
        .req_valid1(req_valid1), .req_ready1(req_ready1),
        .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid0(rsp_valid0), .rsp_ready0(rsp_ready0), .rsp_sum0(rsp_sum0),
        .rsp_valid1(rsp_valid1), .rsp_ready1(rsp_ready1), .rsp_sum1(rsp_sum1),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_full[2];
    int m_sum[2];
    int m_cnt[2];
    int m_last;        // requester served most recently
    bit m_gnt[2];      // grants of the most recent step

    // Pending operand pairs, kept for the hold-while-stalled rule
    int p_a[2], p_b[2];
    bit p_v[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_sum[i] = 0; m_cnt[i] = 0; m_gnt[i] = 0;
        end
        m_last = 1;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".rsp_valid0"}, 32'(rsp_valid0), 32'(m_full[0]));
        chk({tag, ".rsp_valid1"}, 32'(rsp_valid1), 32'(m_full[1]));
        chk({tag, ".rsp_sum0"},   32'(rsp_sum0),   32'(m_sum[0]));
        chk({tag, ".rsp_sum1"},   32'(rsp_sum1),   32'(m_sum[1]));
        chk({tag, ".gnt_cnt0"},   32'(gnt_cnt0),   32'(m_cnt[0]));
        chk({tag, ".gnt_cnt1"},   32'(gnt_cnt1),   32'(m_cnt[1]));
    endtask

    // One clock cycle of traffic.  Inputs are applied 1 time unit after the
    // rising edge.  Combinational outputs are checked mid-cycle, and
    // registered outputs 1 time unit after the next edge.
    task automatic step(input string tag,
                        input bit v0, input int a0, input int b0, input bit r0,
                        input bit v1, input int a1, input int b1, input bit r1);
        bit e[2];
        bit v[2], r[2];
        int a[2], b[2];
        int ea, eb;
        v = '{v0, v1}; r = '{r0, r1};
        a = '{a0, a1}; b = '{b0, b1};
        req_valid0 = v0; req_a0 = 5'(a0); req_b0 = 5'(b0); rsp_ready0 = r0;
        req_valid1 = v1; req_a1 = 5'(a1); req_b1 = 5'(b1); rsp_ready1 = r1;
        // A requester is eligible when it is valid and its slot is free or
        // being drained.  On contention, the one not served last wins.
        for (int i = 0; i < 2; i++) e[i] = v[i] && (!m_full[i] || r[i]);
        m_gnt[0] = e[0] && (!e[1] || m_last == 1);
        m_gnt[1] = e[1] && (!e[0] || m_last == 0);
        ea = m_gnt[0] ? a0 : (m_gnt[1] ? a1 : 0);
        eb = m_gnt[0] ? b0 : (m_gnt[1] ? b1 : 0);
        #2;
        chk({tag, ".req_ready0"}, 32'(req_ready0), 32'(m_gnt[0]));
        chk({tag, ".req_ready1"}, 32'(req_ready1), 32'(m_gnt[1]));
        chk({tag, ".add_a"}, 32'(add_a), 32'(ea));
        chk({tag, ".add_b"}, 32'(add_b), 32'(eb));
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (m_gnt[i]) begin
                m_full[i] = 1;
                m_sum[i]  = a[i] + b[i];
                m_cnt[i]  = (m_cnt[i] + 1) % (1 << CNT_W);
                m_last    = i;
            end else if (r[i]) begin
                m_full[i] = 0;
            end
        end
        #1;
        chk_regs(tag);
    endtask

    // Hold rst high with requests pending.  Nothing may be granted or
    // steered while rst is high, and everything returns to reset values.
    task automatic do_reset(input string tag, input int cycles);
        rst = 1;
        req_valid0 = 1; req_a0 = 5'd9;  req_b0 = 5'd9; rsp_ready0 = 0;
        req_valid1 = 1; req_a1 = 5'd17; req_b1 = 5'd3; rsp_ready1 = 0;
        for (int c = 0; c < cycles; c++) begin
            #2;
            chk({tag, ".rst_ready0"}, 32'(req_ready0), 32'd0);
            chk({tag, ".rst_ready1"}, 32'(req_ready1), 32'd0);
            chk({tag, ".rst_add_a"},  32'(add_a), 32'd0);
            chk({tag, ".rst_add_b"},  32'(add_b), 32'd0);
            @(posedge clk); #1;
        end
        model_reset();
        chk_regs(tag);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        req_valid0 = 0; req_valid1 = 0; rsp_ready0 = 0; rsp_ready1 = 0;
        req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
        model_reset();
        @(posedge clk); #1;

        // Reset state
        do_reset("reset", 2);

        // Single add: 5 + 7
        step("single", 1, 5, 7, 1, 0, 0, 0, 1);
        chk("single.sum_const", 32'(rsp_sum0), 32'd12);
        chk("single.cnt_const", 32'(gnt_cnt0), 32'd1);

        // Carry-out, then zero
        step("carry", 0, 0, 0, 1, 1, 31, 31, 1);
        chk("carry.sum_const", 32'(rsp_sum1), 32'd62);
        step("zero", 0, 0, 0, 1, 1, 0, 0, 1);
        chk("zero.sum_const", 32'(rsp_sum1), 32'd0);

        // Contention: alternate 0,1,0,1 (requester 1 was served last)
        begin
            int c0, c1;
            c0 = m_cnt[0]; c1 = m_cnt[1];
            for (int i = 0; i < 8; i++)
                step("contend", 1, $urandom_range(31), $urandom_range(31), 1,
                                1, $urandom_range(31), $urandom_range(31), 1);
            chk("contend.cnt0_delta", 32'(gnt_cnt0 - CNT_W'(c0)), 32'd4);
            chk("contend.cnt1_delta", 32'(gnt_cnt1 - CNT_W'(c1)), 32'd4);
        end

        // Backpressure on requester 0: 3 + 4 = 7 then stall, requester 1 flows
        step("bp_first", 1, 3, 4, 1, 0, 0, 0, 1);
        chk("bp_first.sum_const", 32'(rsp_sum0), 32'd7);
        for (int i = 0; i < 3; i++) begin
            step("bp_stall", 1, 10, 20, 0, 1, i, 2 * i, 1);
            chk("bp_stall.sum_hold", 32'(rsp_sum0), 32'd7);
        end
        // Drain and refill in the same cycle: requester 0 wins (1 was last)
        step("bp_drain", 1, 10, 20, 1, 1, 5, 5, 1);
        chk("bp_drain.valid_const", 32'(rsp_valid0), 32'd1);
        chk("bp_drain.sum_const",   32'(rsp_sum0),   32'd30);

        // Reset mid-operation with a full slot and both requests pending
        step("pre_rst", 0, 0, 0, 1, 1, 12, 13, 0);
        chk("pre_rst.valid1_const", 32'(rsp_valid1), 32'd1);
        do_reset("mid_rst", 1);
        step("post_rst", 1, 1, 2, 1, 1, 3, 4, 1);
        chk("post_rst.winner0", 32'(req_ready0 | rsp_valid0), 32'd1);
        chk("post_rst.sum0_const", 32'(rsp_sum0), 32'd3);

        // Counter wrap: 256 grants to requester 0 from a clean reset
        do_reset("wrap_rst", 1);
        for (int i = 0; i < 256; i++)
            step("wrap", 1, i % 32, (i * 7) % 32, 1, 0, 0, 0, 1);
        chk("wrap.cnt0_const", 32'(gnt_cnt0), 32'd0);
        chk("wrap.cnt1_const", 32'(gnt_cnt1), 32'd0);

        // Randomized traffic.  Operands and valid are held while a request
        // is stalled.
        for (int i = 0; i < 2; i++) p_v[i] = 0;
        for (int n = 0; n < 400; n++) begin
            bit r[2];
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i]) begin
                    p_v[i] = ($urandom_range(3) != 0);
                    p_a[i] = $urandom_range(31);
                    p_b[i] = $urandom_range(31);
                end
                r[i] = ($urandom_range(2) != 0);
            end
            step("rand", p_v[0], p_a[0], p_b[0], r[0], p_v[1], p_a[1], p_b[1], r[1]);
            for (int i = 0; i < 2; i++) if (m_gnt[i]) p_v[i] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound on run length in case the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cla5_arbiter.md
# cla5_arbiter

Round-robin arbiter that shares one 5-bit carry-look-ahead adder (`cla_5`) between two requesters. Each requester offers an operand pair over a valid/ready handshake. The arbiter steers the granted pair onto the shared adder and captures the 6-bit sum into that requester's one-entry response register, which the requester drains over its own valid/ready handshake. The block sits between client logic and a single `cla_5` instance; the adder stays purely combinational.

## Interface

Parameters:
- `CNT_W`, 8: width of each per-requester grant counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid0`, `req_valid1`  in  1 each  requester has an operand pair.
- `req_ready0`, `req_ready1`  out  1 each  pair accepted this cycle (grant).
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  5 each  operands.
- `rsp_valid0`, `rsp_valid1`  out  1 each  sum available.
- `rsp_ready0`, `rsp_ready1`  in  1 each  requester takes the sum.
- `rsp_sum0`, `rsp_sum1`  out  6 each  registered sum; bit 5 is carry-out.
- `add_a`, `add_b`  out  5 each  operands to the shared `cla_5`.
- `add_sum`  in  6  combinational result from `cla_5`.
- `gnt_cnt0`, `gnt_cnt1`  out  `CNT_W` each  grants issued per requester.

## Operation

- Eligibility: `elig_i = req_valid_i & (!rsp_valid_i | rsp_ready_i)`. A requester is eligible only if its response slot is empty or is being drained in the same cycle.
- Arbitration state is a single bit, `last`, which records the requester granted most recently.
  - One eligible requester: grant it.
  - Both eligible: grant the requester not equal to `last`.
  - None eligible: no grant.
- At most one grant per cycle. `req_ready_i` is 1 only for the granted requester. Both `req_ready` outputs are combinational from the current state and inputs, and are forced to 0 while `rst` is high.
- Adder steering:
  - On a grant, `add_a`/`add_b` carry the granted requester's operands.
  - With no grant, both are 0.
- On grant to requester i at the clock edge:
  - `rsp_sum_i` <= `add_sum`.
  - `rsp_valid_i` <= 1.
  - `last` <= i.
  - `gnt_cnt_i` <= `gnt_cnt_i` + 1. The counter wraps modulo 2^`CNT_W`.
- Drain with no new grant to i (`rsp_valid_i & rsp_ready_i`): `rsp_valid_i` <= 0. `rsp_sum_i` holds its last value.
- Drain and new grant to i in the same cycle: the new sum overwrites the slot and `rsp_valid_i` stays 1. No bubble and no loss.
- Slot full and not draining: `rsp_sum_i` and `rsp_valid_i` hold. Requester i is ineligible, and the other requester is served normally.
- `rsp_ready_i` while `rsp_valid_i` = 0 has no effect.
- Arithmetic: `add_sum` = `add_a` + `add_b`, zero-extended to 6 bits. There is no carry-in. The range is 0..62.

## Timing

- Reset values:
  - `rsp_valid0/1` = 0.
  - `rsp_sum0/1` = 0.
  - `gnt_cnt0/1` = 0.
  - `last` = 1, so requester 0 wins the first contested cycle.
  - `req_ready0/1` = 0 and `add_a`/`add_b` = 0 while `rst` is high.
- Latency: a handshake in cycle N gives `rsp_valid_i` = 1 with the correct sum in cycle N+1.
- Throughput: one add per cycle in aggregate. A single requester that drains every cycle sustains one add per cycle.
- Reset mid-operation: on the first edge with `rst` high, all pending responses are discarded and all state returns to reset values. A `req_valid` asserted during reset is not granted.
- Handshake rule: the requester must hold `req_a_i`/`req_b_i` stable while `req_valid_i` = 1 and `req_ready_i` = 0.

## Test plan

- Single add: `req_valid0`=1, a=5, b=7, `rsp_ready0`=1 → `req_ready0`=1 in the same cycle; `rsp_valid0`=1 with `rsp_sum0`=12 next cycle; `gnt_cnt0`=1.
- Carry-out: requester 1, a=31, b=31 → `rsp_sum1`=62 (bit 5 = 1). Then a=0, b=0 → `rsp_sum1`=0.
- Contention: both requesters valid every cycle, both `rsp_ready`=1 → grants alternate 0,1,0,1. After 8 cycles `gnt_cnt0`=4 and `gnt_cnt1`=4. Each sum matches its own operands.
- Backpressure: `rsp_ready0`=0 after the first sum (3+4=7), requester 0 still valid → `req_ready0`=0, `rsp_sum0` holds 7, requester 1 is granted every cycle. Then set `rsp_ready0`=1 → requester 0 is granted in the drain cycle and `rsp_valid0` stays 1 with the new sum.
- Reset mid-operation: assert `rst` while `rsp_valid1`=1 and both requests pending → next cycle all outputs are at reset values. First contested cycle after reset grants requester 0.
- Counter wrap (`CNT_W`=8): 256 consecutive grants to requester 0 → `gnt_cnt0` returns to 0; `gnt_cnt1` is unchanged.
